// File: rtl/uart_bus_master.sv
// uart_bus_master: parses write/read command frames from a UART byte stream,
// runs one 32-bit transaction on the picorv32 native bus and streams the
// response bytes back towards the UART transmitter.
module uart_bus_master #(
  parameter int FRAME_TIMEOUT = 100000,
  parameter int BUS_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        hold_cpu,
  output logic        overrun
);

  localparam int FW = $clog2(FRAME_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_e;

  state_e          state_q, state_d;
  logic            is_write_q, is_write_d;
  logic [1:0]      idx_q, idx_d;        // byte index while collecting or sending
  logic [1:0]      last_q, last_d;      // index of the final response byte
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     resp_q, resp_d;      // response bytes, LSB sent first
  logic            mem_valid_q, mem_valid_d;
  logic            overrun_q, overrun_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [BW-1:0]   bus_cnt_q, bus_cnt_d;
  logic            frame_timeout;

  // Inter-byte gap limit reached while a frame is still being collected.
  always_comb begin
    frame_timeout = ((state_q == S_ADDR) || (state_q == S_DATA)) &&
                    (frame_cnt_q == FW'(FRAME_TIMEOUT - 1));
  end

  // Next-state and datapath updates for the frame/bus/response sequencer.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    is_write_d  = is_write_q;
    idx_d       = idx_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    mem_valid_d = mem_valid_q;
    overrun_d   = overrun_q;
    frame_cnt_d = '0;
    bus_cnt_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          is_write_d = (rx_data == CMD_WRITE);
          idx_d      = 2'd0;
          if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
            state_d = S_ADDR;
          end else begin
            resp_d  = {24'h0, RSP_NAK};
            last_d  = 2'd0;
            state_d = S_RESP;
          end
        end
      end
      S_ADDR, S_DATA: begin
        // A byte coinciding with the timeout is dropped without overrun.
        if (frame_timeout) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          idx_d = idx_q + 2'd1;
          if (state_q == S_ADDR) addr_d  = {rx_data, addr_q[31:8]};
          else                   wdata_d = {rx_data, wdata_q[31:8]};
          if (idx_q == 2'd3) begin
            state_d = ((state_q == S_ADDR) && is_write_q) ? S_DATA : S_BUS;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + FW'(1);
        end
      end
      S_BUS: begin
        idx_d = 2'd0;
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
        end else if (mem_ready) begin
          mem_valid_d = 1'b0;
          resp_d      = is_write_q ? {24'h0, RSP_ACK} : mem_rdata;
          last_d      = is_write_q ? 2'd0 : 2'd3;
          state_d     = S_RESP;
        end else if (bus_cnt_q == BW'(BUS_TIMEOUT - 1)) begin
          mem_valid_d = 1'b0;
          resp_d      = {24'h0, RSP_NAK};
          last_d      = 2'd0;
          state_d     = S_RESP;
        end else begin
          bus_cnt_d = bus_cnt_q + BW'(1);
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          if (idx_q == last_q) begin
            idx_d   = 2'd0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bytes that arrive while the bus or response phase is busy are lost.
    if (rx_valid && ((state_q == S_BUS) || (state_q == S_RESP))) begin
      overrun_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the data registers are reset as well because they drive
      // mem_addr, mem_wdata and tx_data directly, which must read 0 in reset.
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      mem_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      bus_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      mem_valid_q <= mem_valid_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      bus_cnt_q   <= bus_cnt_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    tx_valid  = (state_q == S_RESP);
    tx_data   = tx_valid ? resp_q[{idx_q, 3'b000} +: 8] : 8'h00;
    mem_valid = mem_valid_q;
    mem_instr = 1'b0;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = wdata_q;
    mem_wstrb = (mem_valid_q && is_write_q) ? 4'hF : 4'h0;
    hold_cpu  = (state_q != S_IDLE);
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: a transaction-level model queues
// the expected bus cycles and response bytes for each frame, and a negedge
// compare process checks the DUT against it on every meaningful cycle.
module tb_uart_bus_master;

  localparam int FRAME_TO = 50;
  localparam int BUS_TO   = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        hold_cpu;
  logic        overrun;

  uart_bus_master #(.FRAME_TIMEOUT(FRAME_TO), .BUS_TIMEOUT(BUS_TO)) dut (
    .clk(clk), .resetn(resetn),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hold_cpu(hold_cpu), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          is_write;
    int          cycles;   // exact mem_valid length, 0 = not checked
  } bus_txn_t;

  bus_txn_t     exp_bus[$];
  logic [7:0]   exp_tx[$];
  logic [7:0]   tx_log[$];
  logic [31:0]  addr_log[$];
  logic [31:0]  wdata_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int valid_run = 0;
  int tx_accepted = 0;
  int ready_delay = 0;        // responder wait cycles, -1 = never ready
  logic [31:0] rd_value = '0;
  int stall_idx = -1;
  int stall_left = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Compare process: bus requests and response bytes against the model.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_bus.delete();
      exp_tx.delete();
      valid_run = 0;
    end else begin
      if (mem_valid) begin
        valid_run++;
        check("bus_pending", 32'(exp_bus.size() > 0), 32'd1);
        check("mem_instr", 32'(mem_instr), 32'd0);
        if (exp_bus.size() > 0) begin
          check("mem_addr", mem_addr, exp_bus[0].addr);
          check("mem_wstrb", 32'(mem_wstrb), 32'(exp_bus[0].wstrb));
          if (exp_bus[0].is_write) check("mem_wdata", mem_wdata, exp_bus[0].wdata);
        end
        if (valid_run == 1) begin
          addr_log.push_back(mem_addr);
          wdata_log.push_back(mem_wdata);
        end
      end else if (valid_run > 0) begin
        if (exp_bus.size() > 0) begin
          if (exp_bus[0].cycles != 0)
            check("mem_valid_cycles", 32'(valid_run), 32'(exp_bus[0].cycles));
          void'(exp_bus.pop_front());
        end
        valid_run = 0;
      end
      if (tx_valid) begin
        check("tx_pending", 32'(exp_tx.size() > 0), 32'd1);
        if (exp_tx.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_tx[0]));
        if (tx_ready) begin
          tx_log.push_back(tx_data);
          if (exp_tx.size() > 0) void'(exp_tx.pop_front());
          tx_accepted++;
        end
      end
    end
  end

  // Bus responder: mem_ready after ready_delay wait cycles, or never.
  initial begin : responder
    int waitc;
    waitc = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (mem_valid && ready_delay >= 0) begin
        if (waitc == ready_delay) begin
          mem_ready = 1'b1;
          mem_rdata = rd_value;
          waitc = 0;
        end else begin
          waitc++;
        end
      end else begin
        waitc = 0;
      end
    end
  end

  // Transmitter: always ready except for an armed stall on one byte index.
  initial begin : transmitter
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && tx_valid && tx_accepted == stall_idx) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d,
                              input int delay);
    ready_delay = delay;
    exp_bus.push_back('{addr: a & ~32'h3, wdata: d, wstrb: 4'hF, is_write: 1'b1,
                        cycles: (delay < 0) ? BUS_TO : delay + 1});
    exp_tx.push_back((delay < 0) ? 8'h15 : 8'h06);
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [31:0] r,
                             input int delay);
    ready_delay = delay;
    rd_value    = r;
    exp_bus.push_back('{addr: a & ~32'h3, wdata: 32'h0, wstrb: 4'h0, is_write: 1'b0,
                        cycles: (delay < 0) ? BUS_TO : delay + 1});
    if (delay < 0) exp_tx.push_back(8'h15);
    else for (int i = 0; i < 4; i++) exp_tx.push_back(r[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0 || hold_cpu) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, 32'(n < 2000), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_mem_valid(input string name);
    int n;
    n = 0;
    while (!mem_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_mem_valid_seen"}, 32'(mem_valid), 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset values.
    #23;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_instr", 32'(mem_instr), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_hold_cpu", 32'(hold_cpu), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // Write 0xDEADBEEF to 0x1000.
    expect_write(32'h0000_1000, 32'hDEAD_BEEF, 0);
    send_byte(8'h57);
    check("wr_hold_rises", 32'(hold_cpu), 32'd1);
    send_word(32'h0000_1000);
    send_word(32'hDEAD_BEEF);
    wait_idle("write");
    check("wr_addr_literal", addr_log[addr_log.size()-1], 32'h0000_1000);
    check("wr_data_literal", wdata_log[wdata_log.size()-1], 32'hDEAD_BEEF);
    check("wr_ack_literal", 32'(tx_log[tx_log.size()-1]), 32'h06);
    check("wr_hold_falls", 32'(hold_cpu), 32'd0);

    // Read from 0x8, 3 wait cycles, 5-cycle transmitter stall on byte 1.
    base = tx_log.size();
    stall_idx  = tx_accepted + 1;
    stall_left = 5;
    expect_read(32'h0000_0008, 32'h1234_5678, 3);
    send_byte(8'h52);
    send_word(32'h0000_0008);
    begin
      int n;
      n = 0;
      while (!(tx_valid && !tx_ready) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("rd_stall_seen", 32'(n < 200), 32'd1);
      for (int i = 0; i < 5; i++) begin
        check("rd_stall_hold", 32'(tx_data), 32'h56);
        @(negedge clk);
      end
    end
    wait_idle("read");
    check("rd_byte0", 32'(tx_log[base]), 32'h78);
    check("rd_byte1", 32'(tx_log[base+1]), 32'h56);
    check("rd_byte2", 32'(tx_log[base+2]), 32'h34);
    check("rd_byte3", 32'(tx_log[base+3]), 32'h12);

    // Unknown command gives NAK, then a read with A0 low bits set.
    exp_tx.push_back(8'h15);
    send_byte(8'h41);
    wait_idle("bad_cmd");
    check("nak_literal", 32'(tx_log[tx_log.size()-1]), 32'h15);
    expect_read(32'h0000_0107, 32'hCAFE_F00D, 1);
    send_byte(8'h52);
    send_word(32'h0000_0107);
    wait_idle("read_after_nak");
    check("addr_low_bits_literal", addr_log[addr_log.size()-1], 32'h0000_0104);

    // Frame timeout: partial write frame is abandoned silently.
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h10);
    check("fto_hold_during", 32'(hold_cpu), 32'd1);
    repeat (60) @(negedge clk);
    check("fto_hold_cleared", 32'(hold_cpu), 32'd0);
    check("fto_no_tx", 32'(tx_valid), 32'd0);
    check("fto_no_overrun", 32'(overrun), 32'd0);
    expect_write(32'h0000_2000, 32'hA5A5_5A5A, 2);
    send_byte(8'h57);
    send_word(32'h0000_2000);
    send_word(32'hA5A5_5A5A);
    wait_idle("write_after_fto");

    // Bus timeout on a read, with a byte injected during the bus phase.
    expect_read(32'h0000_0040, 32'h0, -1);
    send_byte(8'h52);
    send_word(32'h0000_0040);
    wait_mem_valid("bto");
    check("ovr_before", 32'(overrun), 32'd0);
    send_byte(8'hAA);
    check("ovr_set", 32'(overrun), 32'd1);
    wait_idle("bus_timeout");
    check("bto_nak_literal", 32'(tx_log[tx_log.size()-1]), 32'h15);
    check("ovr_sticky", 32'(overrun), 32'd1);
    pulse_reset();
    check("ovr_cleared_by_reset", 32'(overrun), 32'd0);

    // Reset asserted while the bus request is outstanding.
    ready_delay = -1;
    exp_bus.push_back('{addr: 32'h0000_0300, wdata: 32'h0, wstrb: 4'h0,
                        is_write: 1'b0, cycles: 0});
    send_byte(8'h52);
    send_word(32'h0000_0300);
    wait_mem_valid("mid_reset");
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_mem_valid", 32'(mem_valid), 32'd0);
    check("async_rst_hold_cpu", 32'(hold_cpu), 32'd0);
    check("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    expect_write(32'h0000_0020, 32'h0BAD_F00D, 1);
    send_byte(8'h57);
    send_word(32'h0000_0020);
    send_word(32'h0BAD_F00D);
    wait_idle("write_after_reset");
    check("post_rst_addr_literal", addr_log[addr_log.size()-1], 32'h0000_0020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
Serial debug bridge acting as a native-bus initiator, the opposite side of the memory-mapped responders in the system top. It parses command bytes from a UART receiver byte stream and issues single 32-bit read or write transactions using the picorv32 mem_valid/mem_ready handshake. It returns response bytes to a UART transmitter byte stream. It is used for firmware load and peek/poke, muxed onto the bus ahead of the CPU while hold_cpu is asserted.

Parameters:
FRAME_TIMEOUT, 100000, maximum number of clk cycles allowed between bytes inside one frame before the frame is aborted.
BUS_TIMEOUT, 1024, maximum number of clk cycles mem_valid may wait for mem_ready before the transaction is abandoned.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_valid  out  1  response byte available
tx_data  out  8  response byte
tx_ready  in  1  transmitter accepts tx_data this cycle
mem_valid  out  1  bus request
mem_instr  out  1  tied 0
mem_addr  out  32  byte address, low 2 bits forced 0
mem_wdata  out  32  write data
mem_wstrb  out  4  4'hF for write, 4'h0 for read
mem_ready  in  1  responder completion
mem_rdata  in  32  read data, valid when mem_ready=1
hold_cpu  out  1  high from command byte accepted until final response byte accepted
overrun  out  1  sticky; set when a byte is dropped; cleared only by reset

Behaviour:
- Reset is asynchronous and active-low: clk is the only clock; resetn asserts asynchronously and deasserts synchronously to clk.
- Values while reset is asserted: every output is 0, the FSM is in IDLE, and all counters are 0.
- Frame formats (all multi-byte fields LSB first):
  - Write: 0x57, A0..A3, D0..D3. The block performs a write, then responds with 0x06.
  - Read: 0x52, A0..A3. The block performs a read, then responds with R0..R3.
  - Any other command byte: respond with 0x15 (NAK) and return to IDLE.
- FSM states and transitions:
  - IDLE: on rx_valid, latch the command and set hold_cpu. 0x57 or 0x52 -> ADDR. Otherwise -> RESP with a 1-byte NAK.
  - ADDR: collect 4 bytes using idx 0..3. After the 4th byte: write -> DATA, read -> BUS.
  - DATA: collect 4 bytes. After the 4th byte -> BUS.
  - BUS: assert mem_valid on the cycle after entry. Hold mem_addr, mem_wdata and mem_wstrb stable until mem_ready=1 is sampled. On that edge, drop mem_valid and capture mem_rdata for reads. Then -> RESP.
  - RESP: present bytes in order on tx_valid/tx_data. Advance only on a tx_valid&&tx_ready cycle. tx_data stays stable while tx_ready=0. After the last byte is accepted, clear hold_cpu -> IDLE.
- Byte latency: one clk from rx_valid to the byte being registered.
- Write-to-response latency: the earliest mem_valid is 1 cycle after the 9th byte. The earliest tx_valid is 1 cycle after mem_ready.
- Frame timeout: the counter resets on every accepted byte. If it reaches FRAME_TIMEOUT in ADDR or DATA, return to IDLE. No bus cycle is issued, no response is sent, and hold_cpu is cleared.
- Bus timeout: the counter runs in BUS. If it reaches BUS_TIMEOUT without mem_ready, deassert mem_valid and respond with a 1-byte NAK 0x15 (also for reads).
- Bytes arriving in BUS or RESP are dropped and set overrun; FSM behaviour is unchanged.
- If rx_valid arrives on the same cycle as a frame timeout, the timeout wins and the byte is dropped. overrun is not set in this case.
- mem_ready while mem_valid=0 is ignored.
- Address low bits: mem_addr[1:0] is forced to 0 and A0[1:0] is discarded.

Test Plan:
- Write: send 57 00 10 00 00 EF BE AD DE -> one mem_valid cycle with mem_addr=0x00001000, mem_wdata=0xDEADBEEF, mem_wstrb=F. Then tx 0x06. hold_cpu rises at the 0x57 byte and falls after the ACK is accepted.
- Read: send 52 08 00 00 00 with the responder returning 0x12345678 after 3 wait cycles -> mem_wstrb=0, mem_addr=0x8. Then tx bytes 78 56 34 12. With tx_ready low for 5 cycles on the second byte, tx_data holds 0x56.
- Bad command: send 0x41 -> tx 0x15 with no mem_valid. A subsequent valid read frame completes normally.
- Frame timeout: with FRAME_TIMEOUT=50, send 57 00 10, then idle for 60 cycles -> no bus cycle, no tx, and hold_cpu=0. A following full write frame succeeds.
- Bus timeout and overrun: with BUS_TIMEOUT=16 and mem_ready held 0, send a read frame -> mem_valid high for exactly 16 cycles, then tx 0x15. A byte injected during BUS sets overrun=1, which stays set until resetn pulses low.
- Reset mid-operation: assert resetn low while in BUS with mem_valid=1 -> mem_valid, hold_cpu and tx_valid drop to 0 asynchronously. After release, a write frame works.
